// File: rtl/baud_pkg.sv
// Shared defaults and helpers for the fractional baud tick generator.
package baud_pkg;

  localparam int DFLT_CNT_W  = 16;
  localparam int DFLT_FRAC_W = 4;
  localparam int DFLT_OVS    = 16;
  // 100 MHz / (115200 * 16) = 54.25 -> 54 + 4/16
  localparam int DFLT_INT    = 54;
  localparam int DFLT_FRAC   = 4;
  localparam int MIN_DIV     = 2;

  function automatic int phase_w(input int ovs);
    return (ovs <= 2) ? 1 : $clog2(ovs);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds the fractional divisor each period start
// and turns the carry into one extra clk cycle of the current period.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int CNT_W  = DFLT_CNT_W,
  parameter int FRAC_W = DFLT_FRAC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              step,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic [CNT_W-1:0]  period
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  logic [CNT_W-1:0]  eff_int;
  logic [CNT_W:0]    wide;

  assign sum     = {1'b0, acc} + {1'b0, div_frac};
  assign eff_int = (div_int < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_int;
  assign wide    = {1'b0, eff_int} + {{CNT_W{1'b0}}, sum[FRAC_W]};
  // Saturate rather than wrap when the carry lands on an all-ones divisor.
  assign period  = wide[CNT_W] ? {CNT_W{1'b1}} : wide[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample/bit tick generator with glitch-free divisor update
// and phase realignment for RX start-bit synchronisation.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CNT_W    = DFLT_CNT_W,
  parameter int FRAC_W   = DFLT_FRAC_W,
  parameter int OVS      = DFLT_OVS,
  parameter int DEF_INT  = DFLT_INT,
  parameter int DEF_FRAC = DFLT_FRAC,
  localparam int PH_W    = phase_w(OVS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              phase_clr,
  output logic              os_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   phase
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

  logic [CNT_W-1:0]  shadow_int;
  logic [FRAC_W-1:0] shadow_frac;
  logic [CNT_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period;
  logic              running;
  logic              period_start;
  logic              tick;

  // The shadow is only consulted at a period start, so it also serves as the
  // active divisor; a load landing on a period start takes effect right away.
  assign sel_int  = div_load ? div_int  : shadow_int;
  assign sel_frac = div_load ? div_frac : shadow_frac;

  assign period_start = en && (!running || (cnt == '0) || phase_clr);
  assign tick         = en && running && (cnt == '0) && !phase_clr;

  baud_frac_acc #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (!en),
    .step     (period_start),
    .div_int  (sel_int),
    .div_frac (sel_frac),
    .period   (period)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_int  <= CNT_W'(DEF_INT);
      shadow_frac <= FRAC_W'(DEF_FRAC);
    end else if (div_load) begin
      shadow_int  <= div_int;
      shadow_frac <= div_frac;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      cnt      <= '0;
      phase    <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (!en) begin
      running  <= 1'b0;
      cnt      <= '0;
      phase    <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      running  <= 1'b1;
      os_tick  <= tick;
      bit_tick <= tick && (phase == PH_LAST);
      if (period_start) begin
        cnt <= period - 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
      if (phase_clr) begin
        phase <= '0;
      end else if (tick) begin
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: a timing model predicts every os_tick
// (edge number, bit_tick, phase) and a negedge monitor pops and compares.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        phase_clr;
  logic        os_tick;
  logic        bit_tick;
  logic [3:0]  phase;

  typedef struct {
    int t;
    int bt;
    int ph;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_t, m_acc, m_phase;
  int   last_tick = 0, last_bit = 0, prev_bit = 0;
  int   start;

  baud_gen_frac dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_load  (div_load),
    .phase_clr (phase_clr),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Model of one run of n periods from the last period start m_t.
  function automatic void schedule(input int n, input int di, input int df);
    for (int i = 0; i < n; i++) begin
      int s, c, p, bt;
      s = m_acc + df;
      c = s >> 4;
      m_acc = s & 15;
      p = ((di < 2) ? 2 : di) + c;
      if (p > 65535) p = 65535;
      m_t += p;
      bt = (m_phase == 15) ? 1 : 0;
      m_phase = bt ? 0 : m_phase + 1;
      sb.push_back('{m_t, bt, m_phase});
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (bit_tick) checkOutput("bit_needs_os", int'(os_tick), 1);
      if (os_tick) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_tick", cyc, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("tick_edge", cyc, e.t);
          checkOutput("bit_tick", int'(bit_tick), e.bt);
          checkOutput("phase", int'(phase), e.ph);
        end
        last_tick = cyc;
        if (bit_tick) begin
          prev_bit = last_bit;
          last_bit = cyc;
        end
      end
    end
  end

  task automatic applyStimulus(input logic en_v, input logic load_v,
                               input logic [15:0] di, input logic [3:0] df);
    @(negedge clk);
    en       = en_v;
    div_int  = di;
    div_frac = df;
    div_load = load_v;
    if (en_v) begin
      m_t     = cyc + 1;
      m_acc   = 0;
      m_phase = 0;
      start   = m_t;
    end
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic loadDiv(input logic [15:0] di, input logic [3:0] df);
    @(negedge clk);
    div_int  = di;
    div_frac = df;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic stopGen();
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int b;
    b = budget;
    while (sb.size() > 0 && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    div_int   = '0;
    div_frac  = '0;
    div_load  = 1'b0;
    phase_clr = 1'b0;
    #12;
    checkOutput("rst_os_tick", int'(os_tick), 0);
    checkOutput("rst_bit_tick", int'(bit_tick), 0);
    checkOutput("rst_phase", int'(phase), 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] default divisor 54/4");
    applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
    schedule(16, 54, 4);
    waitDrain(1200);
    checkOutput("bit_868", last_bit - start, 868);

    $display("[TB] divisor 4/0");
    stopGen();
    loadDiv(16'd4, 4'd0);
    applyStimulus(1'b1, 1'b0, 16'd4, 4'd0);
    schedule(32, 4, 0);
    waitDrain(400);
    checkOutput("bit_period_64", last_bit - prev_bit, 64);

    $display("[TB] divisor 4/8 over 1000 ticks");
    stopGen();
    applyStimulus(1'b0, 1'b1, 16'd4, 4'd8);
    applyStimulus(1'b1, 1'b0, 16'd4, 4'd8);
    schedule(1000, 4, 8);
    waitDrain(6000);
    checkOutput("avg_4p5", last_tick - start, 4500);

    $display("[TB] divisor change mid-period");
    stopGen();
    applyStimulus(1'b0, 1'b1, 16'd54, 4'd4);
    applyStimulus(1'b1, 1'b0, 16'd54, 4'd4);
    schedule(1, 54, 4);
    repeat (20) @(negedge clk);
    loadDiv(16'd10, 4'd0);
    schedule(3, 10, 0);
    waitDrain(200);
    checkOutput("first_after_load", last_tick - start, 54 + 30);

    $display("[TB] phase_clr on terminal count");
    repeat (9) @(negedge clk);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    #1;
    checkOutput("clr_os_tick", int'(os_tick), 0);
    checkOutput("clr_phase", int'(phase), 0);
    m_t     = cyc;
    m_phase = 0;
    schedule(2, 10, 0);
    waitDrain(100);

    $display("[TB] clamped divisors 0 and 1");
    stopGen();
    loadDiv(16'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
    schedule(4, 0, 0);
    waitDrain(50);
    stopGen();
    loadDiv(16'd1, 4'd0);
    applyStimulus(1'b1, 1'b0, 16'd1, 4'd0);
    schedule(4, 1, 0);
    waitDrain(50);

    $display("[TB] async reset mid-run");
    reset_n = 1'b0;
    #1;
    checkOutput("async_os_tick", int'(os_tick), 0);
    checkOutput("async_bit_tick", int'(bit_tick), 0);
    checkOutput("async_phase", int'(phase), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_t     = cyc + 1;
    m_acc   = 0;
    m_phase = 0;
    start   = m_t;
    schedule(1, 54, 4);
    waitDrain(100);
    checkOutput("post_reset_period", last_tick - start, 54);

    stopGen();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
